// File: rtl/byte_lane_ram_if.sv
// Request/response bundle for byte_lane_ram: valid/ready request channel,
// fixed-latency read response and the zero-fill control pair.
interface byte_lane_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    clear_req;
  logic                    clear_busy;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output clear_req, req_valid, req_we, req_be, req_addr, req_wdata,
    input  clear_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  clear_req, req_valid, req_we, req_be, req_addr, req_wdata,
    output clear_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/byte_lane_ram.sv
// Single-port synchronous RAM with byte-lane writes, a fixed-latency read
// pipeline, out-of-range error responses and a hardware zero-fill sweep.
module byte_lane_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  byte_lane_ram_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [ADDR_WIDTH-1:0] sweep_addr_next;
  logic                  sweep_we;
  logic                  ready;
  logic                  accept;
  logic                  in_range;
  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      sweep_idx;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  pipe_valid [RD_LATENCY];
  logic                  pipe_err   [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data  [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      sweep_addr <= '0;
    end else begin
      state      <= state_next;
      sweep_addr <= sweep_addr_next;
    end
  end

  // clear_req is only looked at in IDLE, so a running sweep never restarts
  always_comb begin
    state_next      = state;
    sweep_addr_next = sweep_addr;
    sweep_we        = 1'b0;
    ready           = 1'b0;
    case (state)
      CLEAR: begin
        sweep_we = 1'b1;
        if (sweep_addr == LAST_ADDR) begin
          state_next      = IDLE;
          sweep_addr_next = '0;
        end else begin
          sweep_addr_next = sweep_addr + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (bus.clear_req) begin
          state_next      = CLEAR;
          sweep_addr_next = '0;
        end
      end
      default: begin
        state_next      = CLEAR;
        sweep_addr_next = '0;
      end
    endcase
  end

  assign bus.req_ready  = ready;
  assign bus.clear_busy = (state == CLEAR);

  assign accept    = bus.req_valid && ready;
  assign in_range  = ({1'b0, bus.req_addr} < DEPTH_LIMIT);
  assign req_idx   = bus.req_addr[IDX_W-1:0];
  assign sweep_idx = sweep_addr[IDX_W-1:0];

  // Storage is deliberately left out of reset; the sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (accept && bus.req_we && in_range) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.req_be[i]) begin
          mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_err[i]   <= 1'b0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= accept && !bus.req_we;
      pipe_err[0]   <= accept && !bus.req_we && !in_range;
      pipe_data[0]  <= (accept && !bus.req_we && in_range) ? mem[req_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign bus.rsp_valid = pipe_valid[RD_LATENCY-1];
  assign bus.rsp_err   = pipe_err[RD_LATENCY-1];
  assign bus.rsp_rdata = pipe_data[RD_LATENCY-1];

endmodule
